// File: rtl/irq_pkg.sv
// Shared constants for the platform interrupt controller.
// Reserved I/O port map and source-width helpers.
package irq_pkg;

  localparam int MAX_SOURCES = 16;

  localparam logic [8:0] STATUS_PORT = 9'd4;
  localparam logic [8:0] MASK_PORT   = 9'd5;
  localparam logic [8:0] ACK_PORT    = 9'd6;
  localparam logic [8:0] INDEX_PORT  = 9'd7;

  localparam logic [15:0] NO_PENDING = 16'h8000;

  function automatic logic [15:0] src_valid(input int n);
    logic [31:0] ones;
    ones = (32'h1 << n) - 32'h1;
    return ones[15:0];
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side I/O bus seen by the interrupt controller.
// The CPU is master; the controller is slave.
interface irq_controller_if;

  logic [8:0]  io_port;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic        irq;

  modport master (
    output io_port, data_out, data_out_valid,
    input  rd_data, rd_hit, irq
  );

  modport slave (
    input  io_port, data_out, data_out_valid,
    output rd_data, rd_hit, irq
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder over a 16-bit request vector.
// Bit 0 has the highest priority.
module irq_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  index,
  output logic        valid
);

  always_comb begin
    index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) index = 4'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches sources, applies mask,
// drives the CPU irq line and serves ports 4..7.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SOURCES = 8,
  parameter logic [15:0] EDGE_MASK   = 16'h0000,
  parameter logic [8:0]  STATUS_PORT = irq_pkg::STATUS_PORT,
  parameter logic [8:0]  MASK_PORT   = irq_pkg::MASK_PORT,
  parameter logic [8:0]  ACK_PORT    = irq_pkg::ACK_PORT,
  parameter logic [8:0]  INDEX_PORT  = irq_pkg::INDEX_PORT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] src,
  irq_controller_if.slave        bus
);

  localparam logic [15:0] VALID = src_valid(NUM_SOURCES);
  localparam logic [15:0] EDGE  = EDGE_MASK & VALID;
  localparam logic [15:0] LEVEL = ~EDGE_MASK & VALID;

  logic [15:0] src_w;
  logic [15:0] src_q;
  logic [15:0] src_d;
  logic [15:0] edge_q;
  logic [15:0] mask_q;
  logic        irq_q;

  logic [15:0] set;
  logic [15:0] clr;
  logic [15:0] edge_next;
  logic [15:0] pending;
  logic [15:0] pending_next;
  logic [15:0] mask_next;
  logic [15:0] active;
  logic        wr_mask;
  logic        wr_ack;
  logic [3:0]  idx;
  logic        idx_valid;

  always_comb begin
    src_w = '0;
    src_w[NUM_SOURCES-1:0] = src;
  end

  assign wr_mask = bus.data_out_valid &&
                   (bus.io_port == MASK_PORT);
  assign wr_ack  = bus.data_out_valid &&
                   (bus.io_port == ACK_PORT);

  // Edge detect runs on the registered sample so
  // a rise seen at E0 becomes pending at E1.
  assign set       = src_q & ~src_d & EDGE;
  assign clr       = wr_ack ? (bus.data_out & EDGE) : '0;
  assign edge_next = set | (edge_q & ~clr);

  assign pending      = (edge_q & EDGE) | (src_q & LEVEL);
  assign pending_next = edge_next | (src_w & LEVEL);
  assign mask_next    = wr_mask ? (bus.data_out & VALID)
                                : mask_q;
  assign active       = pending & mask_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q  <= '0;
      src_d  <= '0;
      edge_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      src_q  <= src_w;
      src_d  <= src_q;
      edge_q <= edge_next;
      mask_q <= mask_next;
      irq_q  <= |(pending_next & mask_next);
    end
  end

  assign bus.irq = irq_q;

  irq_prio_enc u_prio (
    .vec   (active),
    .index (idx),
    .valid (idx_valid)
  );

  // Reads have no strobe, so this path is purely combinational.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_hit  = 1'b0;
    unique case (1'b1)
      (bus.io_port == STATUS_PORT): begin
        bus.rd_data = active;
        bus.rd_hit  = 1'b1;
      end
      (bus.io_port == MASK_PORT): begin
        bus.rd_data = mask_q;
        bus.rd_hit  = 1'b1;
      end
      (bus.io_port == INDEX_PORT): begin
        bus.rd_data = idx_valid ? {12'h000, idx}
                                : NO_PENDING;
        bus.rd_hit  = 1'b1;
      end
      default: begin
        bus.rd_data = '0;
        bus.rd_hit  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller.
// Sources 1 is level, all others edge.
module tb_irq_controller;

  localparam logic [8:0] K_IRQ = 9'h1FF;
  localparam int K_DATA = 0;
  localparam int K_HIT  = 1;

  typedef struct {
    string       tag;
    int          kind;
    logic [8:0]  port;
    logic [15:0] exp;
  } sb_t;

  logic       clock;
  logic       reset;
  logic [7:0] src;

  int n_cmp;
  int n_bad;
  sb_t sb_q[$];

  irq_controller_if bus ();

  irq_controller #(
    .NUM_SOURCES (8),
    .EDGE_MASK   (16'hFFFD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .src   (src),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind,
                      input logic [8:0] port,
                      input logic [15:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [15:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port == K_IRQ) begin
        got = {15'h0, bus.irq};
      end else begin
        bus.io_port = e.port;
        #1;
        if (e.kind == K_HIT) got = {15'h0, bus.rd_hit};
        else got = bus.rd_data;
      end
      check(e.tag, got, e.exp);
    end
    bus.io_port = 9'd0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic wr(input logic [8:0] port,
                    input logic [15:0] data);
    bus.io_port        = port;
    bus.data_out       = data;
    bus.data_out_valid = 1'b1;
    @(negedge clock);
    bus.data_out_valid = 1'b0;
    bus.io_port        = 9'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    src   = 8'h00;
    bus.io_port        = 9'd0;
    bus.data_out       = 16'h0;
    bus.data_out_valid = 1'b0;
    tick(2);

    push("rst_irq", K_DATA, K_IRQ, 16'h0);
    push("rst_stat", K_DATA, 9'd4, 16'h0);
    push("rst_mask", K_DATA, 9'd5, 16'h0);
    push("rst_idx", K_DATA, 9'd7, 16'h8000);
    push("rst_hit5", K_HIT, 9'd5, 16'h1);
    drain();
    reset = 1'b0;
    tick(1);

    src[0] = 1'b1;
    tick(3);
    src[0] = 1'b0;
    push("m0_stat", K_DATA, 9'd4, 16'h0);
    push("m0_irq", K_DATA, K_IRQ, 16'h0);
    push("m0_idx", K_DATA, 9'd7, 16'h8000);
    drain();
    wr(9'd6, 16'h0001);

    wr(9'd5, 16'h0005);
    push("mask5", K_DATA, 9'd5, 16'h0005);
    drain();
    src[2] = 1'b1;
    tick(1);
    push("lat_e0_irq", K_DATA, K_IRQ, 16'h0);
    drain();
    tick(1);
    push("lat_e1_irq", K_DATA, K_IRQ, 16'h1);
    push("lat_stat", K_DATA, 9'd4, 16'h0004);
    push("lat_idx", K_DATA, 9'd7, 16'h0002);
    drain();
    tick(3);
    push("held_stat", K_DATA, 9'd4, 16'h0004);
    drain();
    src[2] = 1'b0;
    tick(2);

    wr(9'd5, 16'h0024);
    src[5] = 1'b1;
    tick(2);
    src[5] = 1'b0;
    push("two_idx", K_DATA, 9'd7, 16'h0002);
    push("two_stat", K_DATA, 9'd4, 16'h0024);
    push("two_irq", K_DATA, K_IRQ, 16'h1);
    drain();
    wr(9'd6, 16'h0004);
    push("ack2_idx", K_DATA, 9'd7, 16'h0005);
    push("ack2_irq", K_DATA, K_IRQ, 16'h1);
    drain();
    wr(9'd6, 16'h0020);
    push("ack5_irq", K_DATA, K_IRQ, 16'h0);
    push("ack5_stat", K_DATA, 9'd4, 16'h0);
    push("ack5_idx", K_DATA, 9'd7, 16'h8000);
    drain();

    src[2] = 1'b1;
    tick(1);
    wr(9'd6, 16'h0004);
    push("race_stat", K_DATA, 9'd4, 16'h0004);
    push("race_irq", K_DATA, K_IRQ, 16'h1);
    drain();
    src[2] = 1'b0;
    wr(9'd6, 16'h0004);
    push("race_clr", K_DATA, K_IRQ, 16'h0);
    drain();
    tick(2);

    wr(9'd5, 16'h0002);
    src[1] = 1'b1;
    push("lvl_pre", K_DATA, K_IRQ, 16'h0);
    drain();
    tick(1);
    push("lvl_irq", K_DATA, K_IRQ, 16'h1);
    push("lvl_stat", K_DATA, 9'd4, 16'h0002);
    drain();
    wr(9'd6, 16'h0002);
    push("lvl_ack_irq", K_DATA, K_IRQ, 16'h1);
    push("lvl_ack_st", K_DATA, 9'd4, 16'h0002);
    drain();
    src[1] = 1'b0;
    tick(1);
    push("lvl_low", K_DATA, K_IRQ, 16'h0);
    drain();

    wr(9'd5, 16'h00FF);
    src = 8'hFF;
    tick(3);
    push("all_stat", K_DATA, 9'd4, 16'h00FF);
    push("all_irq", K_DATA, K_IRQ, 16'h1);
    push("all_idx", K_DATA, 9'd7, 16'h0000);
    drain();
    reset = 1'b1;
    wr(9'd5, 16'h00FF);
    push("mid_irq", K_DATA, K_IRQ, 16'h0);
    push("mid_stat", K_DATA, 9'd4, 16'h0);
    push("mid_mask", K_DATA, 9'd5, 16'h0);
    drain();
    src = 8'h00;
    tick(1);
    reset = 1'b0;
    tick(1);

    wr(9'd5, 16'hFFFF);
    push("wide_mask", K_DATA, 9'd5, 16'h00FF);
    drain();
    wr(9'd4, 16'h00FF);
    wr(9'd7, 16'h00FF);
    push("ro_stat", K_DATA, 9'd4, 16'h0);
    push("ro_idx", K_DATA, 9'd7, 16'h8000);
    push("ack_hit", K_HIT, 9'd6, 16'h0);
    push("ack_data", K_DATA, 9'd6, 16'h0);
    push("miss_hit", K_HIT, 9'h100, 16'h0);
    push("stat_hit", K_HIT, 9'd4, 16'h1);
    drain();
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
